// File: rtl/bullet_sweep_if.sv
// Spawn, kill and read-port bundle between the bullet table and its clients.
// The master side requests spawns/kills and reads slots; the slave owns the table.
interface bullet_sweep_if;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [7:0]  spawn_x;
  logic [15:0] spawn_size;
  logic [2:0]  spawn_color;
  logic        kill_valid;
  logic [2:0]  kill_idx;
  logic [2:0]  rd_idx;
  logic [15:0] rd_pos;
  logic [15:0] rd_size;
  logic [2:0]  rd_color;
  logic        rd_active;

  modport master (
    output spawn_valid, spawn_x, spawn_size, spawn_color,
    output kill_valid, kill_idx, rd_idx,
    input  spawn_ready, rd_pos, rd_size, rd_color, rd_active
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_size, spawn_color,
    input  kill_valid, kill_idx, rd_idx,
    output spawn_ready, rd_pos, rd_size, rd_color, rd_active
  );
endinterface

// File: rtl/bullet_sweep_ctrl.sv
// Bullet table with a once-per-frame downward sweep, spawn allocation and kills.
// Define BULLET_WRAP_EN to recycle bullets at Y_LIMIT back to Y_START.
module bullet_sweep_ctrl #(
  parameter int NUM_SLOTS = 8,
  parameter int STEP      = 5,
  parameter int Y_LIMIT   = 200,
  parameter int Y_START   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          frame_tick,
  bullet_sweep_if.slave bus,
  output logic          busy,
  output logic          sweep_done,
  output logic [3:0]    active_count
);
  localparam int IW = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        idx, idx_nx;
  logic [7:0]           xpos  [NUM_SLOTS];
  logic [7:0]           ypos  [NUM_SLOTS];
  logic [15:0]          size  [NUM_SLOTS];
  logic [2:0]           color [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active, pending, pending_nx, free;
  logic [IW-1:0]        spawn_slot;
  logic                 kill_hit, kill_now, proc, spawn_fire;
  logic [3:0]           count_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    proc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (run && frame_tick) begin
          state_nx = SWEEP;
          idx_nx   = '0;
        end
      end
      SWEEP: begin
        if (!run) begin
          state_nx = IDLE;
        end else begin
          proc = 1'b1;
          if (idx == IW'(NUM_SLOTS - 1))
            state_nx = DONE;
          else
            idx_nx = idx + IW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign sweep_done = (state == DONE);

  assign free = ~active & ~pending;

  always_comb begin
    spawn_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (free[i]) spawn_slot = IW'(i);
  end

  assign bus.spawn_ready = (state == IDLE) & run & (|free);
  assign spawn_fire      = bus.spawn_valid & bus.spawn_ready;

  // A kill aimed at the slot under the sweep bypasses the pending mask.
  assign kill_hit = bus.kill_valid & active[bus.kill_idx];
  assign kill_now = pending[idx] | (kill_hit & (bus.kill_idx == idx));

  always_comb begin
    pending_nx = pending;
    if (kill_hit) pending_nx[bus.kill_idx] = 1'b1;
    if (proc)     pending_nx[idx] = 1'b0;
  end

  always_comb begin
    count_nx = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      count_nx = count_nx + 4'(active[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= '0;
      pending      <= '0;
      active_count <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        xpos[i]  <= '0;
        ypos[i]  <= '0;
        size[i]  <= '0;
        color[i] <= '0;
      end
    end else begin
      pending      <= pending_nx;
      active_count <= count_nx;
      if (spawn_fire) begin
        xpos[spawn_slot]   <= bus.spawn_x;
        ypos[spawn_slot]   <= 8'(Y_START);
        size[spawn_slot]   <= bus.spawn_size;
        color[spawn_slot]  <= bus.spawn_color;
        active[spawn_slot] <= 1'b1;
      end
      if (proc) begin
        if (kill_now) begin
          active[idx] <= 1'b0;
        end else if (active[idx]) begin
          if (ypos[idx] >= 8'(Y_LIMIT)) begin
`ifdef BULLET_WRAP_EN
            ypos[idx] <= 8'(Y_START);
`else
            active[idx] <= 1'b0;
`endif
          end else begin
            ypos[idx] <= ypos[idx] + 8'(STEP);
          end
        end
      end
    end
  end

  assign bus.rd_pos    = {xpos[bus.rd_idx], ypos[bus.rd_idx]};
  assign bus.rd_size   = size[bus.rd_idx];
  assign bus.rd_color  = color[bus.rd_idx];
  assign bus.rd_active = active[bus.rd_idx];
endmodule

// File: tb/tb_bullet_sweep_ctrl.sv
// Bench for bullet_sweep_ctrl: vector table, directed corner sequences and
// randomized traffic checked against a slot-level reference model.
module tb_bullet_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       frame_tick;
  logic       busy;
  logic       sweep_done;
  logic [3:0] active_count;

  bullet_sweep_if bif();

  bullet_sweep_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .frame_tick(frame_tick),
    .bus(bif),
    .busy(busy),
    .sweep_done(sweep_done),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        tick;
    bit        sv;
    bit        e_busy;
    bit        e_done;
    bit        e_ready;
    bit [3:0]  e_cnt;
    bit [15:0] e_pos;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  bit [7:0]  m_x  [8];
  bit [7:0]  m_y  [8];
  bit [15:0] m_sz [8];
  bit [2:0]  m_c  [8];
  bit        m_act  [8];
  bit        m_pend [8];
  int        m_phase;
  int        m_cnt;
  bit [7:0]  pre_y [8];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, need %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_sz[i] = 0; m_c[i] = 0;
      m_act[i] = 0; m_pend[i] = 0;
    end
    m_phase = -1;
    m_cnt   = 0;
  endtask

  function automatic int free_slot();
    for (int i = 0; i < 8; i++)
      if (!m_act[i] && !m_pend[i]) return i;
    return -1;
  endfunction

  task automatic idle_in();
    run = 1; frame_tick = 0;
    bif.spawn_valid = 0; bif.spawn_x = 0;
    bif.spawn_size = 0; bif.spawn_color = 0;
    bif.kill_valid = 0; bif.kill_idx = 0;
  endtask

  // Check outputs against the model, then advance model and DUT by one edge.
  task automatic cycle();
    int f, p, ki, ri;
    bit rdy, hit, proc;
    #1;
    f   = free_slot();
    rdy = (m_phase < 0) && run && (f >= 0);
    ri  = int'(bif.rd_idx);
    check("spawn_ready", 32'(bif.spawn_ready), 32'(rdy));
    check("busy", 32'(busy), 32'(m_phase >= 0));
    check("sweep_done", 32'(sweep_done), 32'(m_phase == 8));
    check("active_count", 32'(active_count), 32'(m_cnt));
    check("rd_pos", 32'(bif.rd_pos), 32'({m_x[ri], m_y[ri]}));
    check("rd_size", 32'(bif.rd_size), 32'(m_sz[ri]));
    check("rd_color", 32'(bif.rd_color), 32'(m_c[ri]));
    check("rd_active", 32'(bif.rd_active), 32'(m_act[ri]));
    m_cnt = 0;
    for (int i = 0; i < 8; i++) if (m_act[i]) m_cnt++;
    ki   = int'(bif.kill_idx);
    hit  = bif.kill_valid && m_act[ki];
    proc = (m_phase >= 0) && (m_phase < 8) && run;
    p    = m_phase;
    if (hit) m_pend[ki] = 1;
    if (proc) begin
      if (m_pend[p]) m_act[p] = 0;
      else if (m_act[p]) begin
        if (m_y[p] >= 8'd200) begin
`ifdef BULLET_WRAP_EN
          m_y[p] = 8'd1;
`else
          m_act[p] = 0;
`endif
        end else m_y[p] = 8'(m_y[p] + 8'd5);
      end
      m_pend[p] = 0;
    end
    if (bif.spawn_valid && rdy) begin
      m_x[f] = bif.spawn_x; m_y[f] = 8'd1;
      m_sz[f] = bif.spawn_size; m_c[f] = bif.spawn_color;
      m_act[f] = 1;
    end
    if (m_phase < 0) begin
      if (run && frame_tick) m_phase = 0;
    end else if (m_phase == 8 || !run) m_phase = -1;
    else m_phase++;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(int i);
    idle_in();
    bif.rd_idx = 3'(i);
    cycle();
  endtask

  task automatic finish_sweep();
    int n = 0;
    while (busy && n < 20) begin
      cycle();
      n++;
    end
    check("sweep_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic run_sweep();
    idle_in();
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    finish_sweep();
  endtask

  function automatic vec_t mk(bit t, bit s, bit b, bit d, bit r,
                              bit [3:0] c, bit [15:0] pos);
    vec_t v;
    v.tick = t; v.sv = s; v.e_busy = b; v.e_done = d;
    v.e_ready = r; v.e_cnt = c; v.e_pos = pos;
    return v;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [12];
    int   n;
    vt[0] = mk(0, 1, 0, 0, 1, 0, 16'h2401);
    vt[1] = mk(0, 0, 0, 0, 1, 1, 16'h2401);
    vt[2] = mk(1, 0, 1, 0, 0, 1, 16'h2401);
    for (int i = 3; i < 10; i++) vt[i] = mk(0, 0, 1, 0, 0, 1, 16'h2406);
    vt[10] = mk(0, 0, 1, 1, 0, 1, 16'h2406);
    vt[11] = mk(0, 0, 0, 0, 1, 1, 16'h2406);

    idle_in();
    bif.rd_idx = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_count", 32'(active_count), 32'd0);
    check("rst_pos", 32'(bif.rd_pos), 32'd0);
    check("rst_active", 32'(bif.rd_active), 32'd0);

    // Vector table: first spawn and one full sweep.
    for (int i = 0; i < 12; i++) begin
      idle_in();
      bif.rd_idx = 0;
      frame_tick = vt[i].tick;
      bif.spawn_valid = vt[i].sv;
      bif.spawn_x = 8'h24;
      bif.spawn_size = 16'h1010;
      bif.spawn_color = 3'd0;
      cycle();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      check($sformatf("vec%0d_done", i), 32'(sweep_done), 32'(vt[i].e_done));
      check($sformatf("vec%0d_ready", i), 32'(bif.spawn_ready), 32'(vt[i].e_ready));
      check($sformatf("vec%0d_count", i), 32'(active_count), 32'(vt[i].e_cnt));
      check($sformatf("vec%0d_pos", i), 32'(bif.rd_pos), 32'(vt[i].e_pos));
      check($sformatf("vec%0d_active", i), 32'(bif.rd_active), 32'd1);
    end
    check("vec_size", 32'(bif.rd_size), 32'h1010);

    // Fill the table, then kill slot 3 and reuse it.
    for (int i = 0; i < 7; i++) begin
      idle_in();
      bif.spawn_valid = 1;
      bif.spawn_x = 8'(8'h30 + i * 16);
      bif.spawn_size = 16'h0808;
      bif.spawn_color = 3'(i % 3);
      cycle();
    end
    idle_in();
    bif.spawn_valid = 1;
    cycle();
    check("full_ready", 32'(bif.spawn_ready), 32'd0);
    check("full_count", 32'(active_count), 32'd8);
    idle_in();
    bif.kill_valid = 1;
    bif.kill_idx = 3;
    cycle();
    run_sweep();
    peek(3);
    check("kill3_gone", 32'(bif.rd_active), 32'd0);
    check("kill3_ready", 32'(bif.spawn_ready), 32'd1);
    idle_in();
    bif.spawn_valid = 1;
    bif.spawn_x = 8'hA3;
    cycle();
    peek(3);
    check("respawn3_active", 32'(bif.rd_active), 32'd1);
    check("respawn3_pos", 32'(bif.rd_pos), 32'hA301);

    // Kill slot 2 exactly as it is swept; kill slot 5 mid-sweep via pending.
    idle_in();
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    cycle();
    cycle();
    bif.kill_valid = 1;
    bif.kill_idx = 2;
    cycle();
    bif.kill_idx = 5;
    cycle();
    bif.kill_valid = 0;
    finish_sweep();
    peek(2);
    check("kill_on_sweep", 32'(bif.rd_active), 32'd0);
    peek(5);
    check("kill_pending", 32'(bif.rd_active), 32'd0);
    idle_in();
    bif.kill_valid = 1;
    bif.kill_idx = 5;
    cycle();
    idle_in();
    bif.spawn_valid = 1;
    bif.spawn_x = 8'h55;
    cycle();
    cycle();
    run_sweep();
    peek(5);
    check("dead_kill_dropped", 32'(bif.rd_active), 32'd1);
    check("dead_kill_pos", 32'(bif.rd_pos), 32'h5506);

    // Drop run with the sweep at index 4.
    for (int i = 0; i < 8; i++) pre_y[i] = m_y[i];
    idle_in();
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    repeat (4) cycle();
    run = 0;
    cycle();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(sweep_done), 32'd0);
    idle_in();
    cycle();
    check("abort_no_done", 32'(sweep_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      peek(i);
      check($sformatf("abort_y%0d", i), 32'(bif.rd_pos[7:0]),
            32'(8'(pre_y[i] + ((i < 4) ? 8'd5 : 8'd0))));
    end

    // Age slot 0 up to the arena limit.
    n = 0;
    while (m_y[0] < 8'd200 && n < 60) begin
      run_sweep();
      n++;
    end
    peek(0);
    check("limit_reached", 32'(bif.rd_pos[7:0] >= 8'd200), 32'd1);
    run_sweep();
    peek(0);
`ifdef BULLET_WRAP_EN
    check("limit_wrap_active", 32'(bif.rd_active), 32'd1);
    check("limit_wrap_y", 32'(bif.rd_pos[7:0]), 32'd1);
`else
    check("limit_despawn", 32'(bif.rd_active), 32'd0);
`endif

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      run = ($urandom_range(0, 19) != 0);
      frame_tick = ($urandom_range(0, 7) == 0);
      bif.spawn_valid = ($urandom_range(0, 3) == 0);
      bif.spawn_x = 8'($urandom);
      bif.spawn_size = 16'($urandom);
      bif.spawn_color = 3'($urandom);
      bif.kill_valid = ($urandom_range(0, 5) == 0);
      bif.kill_idx = 3'($urandom);
      bif.rd_idx = 3'($urandom);
      cycle();
    end

    // Asynchronous reset in the middle of a sweep.
    idle_in();
    bif.rd_idx = 0;
    bif.spawn_valid = 1;
    bif.spawn_x = 8'h11;
    cycle();
    bif.spawn_valid = 0;
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    #2;
    rst_n = 0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_count", 32'(active_count), 32'd0);
    check("async_active", 32'(bif.rd_active), 32'd0);
    check("async_pos", 32'(bif.rd_pos), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) peek(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bullet_sweep_ctrl.md
Name: bullet_sweep_ctrl

Overview:
- Owns the 8-slot bullet table: per-slot y position, x position, size, colour, active flag.
- Once per video frame, sweeps all slots one per cycle to move bullets downward.
- Allocates new bullets from spawn requests and applies kills reported by collision logic.
- Gives the VGA renderer and damage logic a combinational read port; sits between game-state FSM, collision detector and renderer.

Parameters:
- NUM_SLOTS, 8, number of bullet slots (index width 3).
- STEP, 5, y increment per frame.
- Y_LIMIT, 200, y at/above which a bullet leaves the arena.
- Y_START, 1, y given to a newly spawned bullet.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  game running; 0 aborts/blocks sweeps
- frame_tick  input  1  one-cycle pulse per video frame
- spawn_valid  input  1  spawn request
- spawn_ready  output  1  spawn accepted when valid&ready
- spawn_x  input  8  x position of new bullet
- spawn_size  input  16  {width[15:8], height[7:0]}
- spawn_color  input  3  000 white, 001 green, 010 blue
- kill_valid  input  1  collision kill pulse
- kill_idx  input  3  slot to kill
- rd_idx  input  3  read slot select
- rd_pos  output  16  {x[15:8], y[7:0]} of rd_idx
- rd_size  output  16  size of rd_idx
- rd_color  output  3  colour of rd_idx
- rd_active  output  1  active flag of rd_idx
- busy  output  1  sweep in progress
- sweep_done  output  1  one-cycle pulse at sweep end
- active_count  output  4  registered count of active slots

Behaviour:
- Reset (async, rst_n=0): all slots inactive, all fields 0, pending-kill mask 0, state IDLE, busy=0, sweep_done=0, active_count=0.
- Read port is combinational from the table; rd_* always reflect rd_idx, including inactive slots.
- FSM states:
  - IDLE: run&frame_tick -> SWEEP, sweep index=0.
  - SWEEP: processes slot[index] each cycle; index==NUM_SLOTS-1 -> DONE, else index+1.
  - DONE: sweep_done=1 for this one cycle -> IDLE.
- busy=1 in SWEEP and DONE. A full sweep takes NUM_SLOTS+1 cycles from the tick.
- frame_tick outside IDLE is ignored.
- run=0 in SWEEP or DONE: return to IDLE next cycle, no sweep_done. Slots already processed keep their updates.
- Slot processing, in priority order:
  - pending kill: active=0, pending bit cleared;
  - else active and y>=Y_LIMIT: active=0 (despawn);
  - else active: y=y+STEP, 8-bit wrap (cannot occur when Y_LIMIT+STEP<=255);
  - inactive: unchanged.
- Kill: kill_valid sets pending[kill_idx] only if that slot is active that cycle; otherwise dropped. Accepted in any state.
  - Kill of the slot being swept in the same cycle takes effect that cycle.
  - Repeat kills of the same slot are idempotent.
- Spawn: spawn_ready = (state==IDLE) & run & at least one slot both inactive and not pending.
  - On accept: lowest such index gets x=spawn_x, y=Y_START, size, colour, active=1.
  - spawn_ready low when all 8 are busy; requester holds spawn_valid.
- Spawn and kill in the same cycle never target the same slot (kill needs active, spawn needs inactive).
- active_count updates one cycle after any flag change; range 0..8.

Optional Feature:
- Macro BULLET_WRAP_EN.
- Defined: a bullet at y>=Y_LIMIT is set to y=Y_START and stays active (endless curtain pattern); only kills deactivate.
- Undefined: such a bullet is deactivated as described above.

Test Plan:
- Reset, then spawn x=0x24 size=0x1010 colour=000 -> slot 0 active, rd_pos=0x2401, active_count=1 next cycle.
- One frame_tick with run=1 -> busy high 9 cycles, sweep_done pulse on cycle 9, slot 0 y=6.
- Spawn 8 bullets -> spawn_ready=0 with active_count=8; kill_valid idx 3 then a tick -> slot 3 inactive after sweep, spawn_ready=1, next spawn lands in slot 3.
- Bullet at y=200, tick -> inactive without macro; y=1 and active with BULLET_WRAP_EN.
- kill_valid idx 2 on the cycle slot 2 is swept -> slot 2 inactive that sweep; kill of an inactive slot 5 -> no pending bit, later spawn into 5 survives next sweep.
- Drop run at sweep index 4 -> IDLE next cycle, no sweep_done, slots 0-3 advanced, slots 4-7 unchanged.
